// File: rtl/dcache_line_xfer.sv
// dcache_line_xfer: writes back a victim line and/or fills a missing line, one word per memory handshake.
module dcache_line_xfer #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      wb_start,
    input  logic                      fill_start,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [ADDR_W-1:0]         fill_addr,
    input  logic [WORDS*DATA_W-1:0]   wb_line,
    input  logic                      mem_valid,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_we,
    output logic                      mem_rden,
    output logic [WORDS*DATA_W-1:0]   fill_line,
    output logic                      fill_valid,
    output logic                      busy,
    output logic                      done
);
    localparam int IW = $clog2(WORDS);
    localparam int OW = IW + 2;
    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
    state_t                    state;
    logic [IW-1:0]             idx;
    logic                      pending_fill;
    logic [ADDR_W-1:0]         wb_base;
    logic [ADDR_W-1:0]         fill_base;
    logic [WORDS*DATA_W-1:0]   wb_buf;
    logic [ADDR_W-1:0]         offset;
    assign offset    = {{(ADDR_W-OW){1'b0}}, idx, 2'b00};
    assign mem_we    = state == WB;
    assign mem_rden  = state == FILL;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign mem_addr  = mem_we ? (wb_base | offset) : mem_rden ? (fill_base | offset) : '0;
    assign mem_wdata = mem_we ? wb_buf[idx*DATA_W +: DATA_W] : '0;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            idx          <= '0;
            pending_fill <= 1'b0;
            wb_base      <= '0;
            fill_base    <= '0;
            wb_buf       <= '0;
            fill_line    <= '0;
            fill_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (wb_start | fill_start) begin
                    wb_base      <= {wb_addr[ADDR_W-1:OW], {OW{1'b0}}};
                    fill_base    <= {fill_addr[ADDR_W-1:OW], {OW{1'b0}}};
                    wb_buf       <= wb_line;
                    fill_valid   <= 1'b0;
                    idx          <= '0;
                    pending_fill <= wb_start & fill_start;
                    state        <= wb_start ? WB : FILL;
                end
                WB: if (mem_valid) begin
                    idx <= idx + 1'b1;
                    if (&idx)
                        state <= pending_fill ? FILL : DONE;
                end
                FILL: if (mem_valid) begin
                    fill_line[idx*DATA_W +: DATA_W] <= mem_rdata;
                    // idx holds at the last word; the next start rewinds it
                    if (&idx) begin
                        state      <= DONE;
                        fill_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_line_xfer.sv
// tb_dcache_line_xfer: directed vectors plus hand-written reset and busy-start sequences.
module tb_dcache_line_xfer;
    localparam int W = 8;
    logic           CLK = 0, RST = 0, wb_start = 0, fill_start = 0, mem_valid = 0;
    logic [31:0]    wb_addr = 0, fill_addr = 0, mem_rdata = 0;
    logic [255:0]   wb_line = 0;
    logic [31:0]    mem_addr, mem_wdata;
    logic           mem_we, mem_rden, fill_valid, busy, done;
    logic [255:0]   fill_line;
    int             checks = 0, errors = 0, cyc = 0;
    typedef struct {
        logic [31:0] wa, fa, wbase, fbase;
        bit          dw, df;
        int          wt, lat;
    } vec_t;
    vec_t vecs[5];

    dcache_line_xfer #(.WORDS(8), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST), .wb_start(wb_start), .fill_start(fill_start),
        .wb_addr(wb_addr), .fill_addr(fill_addr), .wb_line(wb_line),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rden(mem_rden),
        .fill_line(fill_line), .fill_valid(fill_valid), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // one word: wt stalled cycles, then the handshake cycle
    task automatic word(input bit we, input logic [31:0] a, input logic [31:0] d, input int wt);
        for (int w = 0; w <= wt; w++) begin
            mem_valid = (w == wt);
            mem_rdata = mem_valid ? rd(a) : ~rd(a);
            chk("mem_we", mem_we, we);
            chk("mem_rden", mem_rden, !we);
            chk("mem_addr", mem_addr, a);
            if (we) chk("mem_wdata", mem_wdata, d);
            chk("done_mid", done, 0);
            tick;
        end
        mem_valid = 0;
    endtask

    task automatic run(input vec_t v);
        logic [255:0] lw, exp_fl;
        exp_fl = '0;
        for (int i = 0; i < W; i++) wb_line[i*32 +: 32] = $urandom;
        lw = wb_line;
        wb_addr = v.wa; fill_addr = v.fa; wb_start = v.dw; fill_start = v.df; cyc = 0;
        tick;
        wb_start = 0; fill_start = 0; wb_line = ~lw;
        chk("busy_start", busy, 1);
        chk("fv_clear", fill_valid, 0);
        if (v.dw) for (int i = 0; i < W; i++) word(1, v.wbase + 32'(4*i), lw[i*32 +: 32], v.wt);
        if (v.df) for (int i = 0; i < W; i++) begin
            word(0, v.fbase + 32'(4*i), 0, v.wt);
            exp_fl[i*32 +: 32] = rd(v.fbase + 32'(4*i));
        end
        chk("done", done, 1);
        chk("busy_done", busy, 1);
        chk("latency", cyc, v.lat);
        chk("fill_valid", fill_valid, v.df);
        if (v.df) chk("fill_line", fill_line, exp_fl);
        tick;
        chk("done_clr", done, 0);
        chk("busy_idle", busy, 0);
        chk("fv_hold", fill_valid, v.df);
    endtask

    initial begin
        int dn, at, we_seen;
        logic [255:0] exp_fl;
        vecs[0] = '{wa: 32'h0, fa: 32'h1234, wbase: 32'h0, fbase: 32'h1220, dw: 0, df: 1, wt: 0, lat: 9};
        vecs[1] = '{wa: 32'h2000, fa: 32'h4010, wbase: 32'h2000, fbase: 32'h4000, dw: 1, df: 1, wt: 0, lat: 17};
        vecs[2] = '{wa: 32'h0, fa: 32'h800000FF, wbase: 32'h0, fbase: 32'h800000E0, dw: 0, df: 1, wt: 3, lat: 33};
        vecs[3] = '{wa: 32'hFFFFFFFC, fa: 32'h0, wbase: 32'hFFFFFFE0, fbase: 32'h0, dw: 1, df: 0, wt: 0, lat: 9};
        vecs[4] = '{wa: 32'h1234567B, fa: 32'h3F, wbase: 32'h12345660, fbase: 32'h20, dw: 1, df: 1, wt: 1, lat: 33};
        #2 RST = 1;
        #10;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_rden", mem_rden, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_fv", fill_valid, 0);
        chk("rst_fl", fill_line, 0);
        tick;
        RST = 0;
        tick;
        for (int k = 0; k < 5; k++) run(vecs[k]);

        // starts while busy must be ignored
        fill_addr = 32'h300; fill_start = 1; cyc = 0; dn = 0; at = 0; we_seen = 0;
        tick;
        fill_start = 0; mem_valid = 1;
        for (int c = 0; c < 20; c++) begin
            wb_start = (c == 2);
            fill_start = (c >= 3 && c < 6);
            fill_addr = 32'h7700;
            mem_rdata = rd(mem_addr);
            if (mem_we) we_seen++;
            if (done) begin dn++; at = cyc; end
            tick;
        end
        wb_start = 0; fill_start = 0; mem_valid = 0;
        for (int i = 0; i < W; i++) exp_fl[i*32 +: 32] = rd(32'h300 + 32'(4*i));
        chk("busy_start_dones", dn, 1);
        chk("busy_start_lat", at, 9);
        chk("busy_start_we", we_seen, 0);
        chk("busy_start_line", fill_line, exp_fl);

        // async reset in the middle of a fill at idx 3
        fill_addr = 32'h5678; fill_start = 1;
        tick;
        fill_start = 0; mem_valid = 1;
        for (int i = 0; i < 3; i++) begin mem_rdata = rd(mem_addr); tick; end
        mem_valid = 0;
        chk("mid_addr", mem_addr, 32'h566C);
        chk("mid_rden", mem_rden, 1);
        #2 RST = 1;
        #1;
        chk("abort_rden", mem_rden, 0);
        chk("abort_busy", busy, 0);
        chk("abort_fv", fill_valid, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_fl", fill_line, 0);
        tick;
        RST = 0; mem_valid = 1;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("post_rst_req", {mem_we, mem_rden, busy, done}, 0);
        end
        mem_valid = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
